// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - segment constants, handshake state encoding and BCD decoder
//
// Purpose: shared definitions for the multiplexed BCD display scanner.
//   - SEG_0..SEG_9 : active-low segment patterns, bit order gfedcba
//   - SEG_BLANK    : all segments off
//   - hs_state_e   : load handshake states (IDLE accepts, PEND holds)
//   - seg_decode() : nibble to segment pattern, 10..15 decode to blank
package bcd_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } hs_state_e;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bcd_scan_ctrl_tick_gen.sv
// rtl/bcd_scan_ctrl_tick_gen.sv - prescaler producing one tick per DIV+1 clocks
//
// Purpose: free-running counter 0..DIV; tick is high for the cycle the
//          counter sits at DIV. With DIV=0 tick is permanently high.
// Ports:
//   clkin - clock, posedge
//   rst_n - asynchronous active-low reset
//   tick  - one-cycle strobe (decoded from the counter register only)
module tick_gen #(
  parameter int unsigned DIV = 499
) (
  input  logic clkin,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CW = (DIV > 0) ? $clog2(DIV + 1) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(DIV));

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/bcd_scan_ctrl.sv
// rtl/bcd_scan_ctrl.sv - multiplexed BCD display scanner with load handshake
//
// Purpose: scans NDIG digits at the prescaler tick rate, decoding the active
//          value to active-low segments with optional leading-zero blanking.
//          New values are staged in a pending register and committed on the
//          frame tick so a scan never shows a mix of old and new digits.
// Ports:
//   clkin    - clock, posedge
//   rst_n    - asynchronous active-low reset
//   load     - request to accept bcd_in (honoured only when ready)
//   bcd_in   - packed BCD, bits [3:0] = digit 0
//   blank_lz - leading-zero blanking enable
//   ready    - high while a load would be accepted (IDLE)
//   an       - active-low digit enables
//   seg      - active-low segments, gfedcba
//   frame    - pulse when the last digit of a scan is driven
module bcd_scan_ctrl
  import bcd_pkg::*;
#(
  parameter int unsigned DIV  = 499,
  parameter int unsigned NDIG = 4
) (
  input  logic              clkin,
  input  logic              rst_n,
  input  logic              load,
  input  logic [4*NDIG-1:0] bcd_in,
  input  logic              blank_lz,
  output logic              ready,
  output logic [NDIG-1:0]   an,
  output logic [6:0]        seg,
  output logic              frame
);

  localparam int unsigned IW = $clog2(NDIG);
  localparam logic [IW-1:0] LAST_IDX = IW'(NDIG - 1);

  logic tick;
  logic frame_tick;

  hs_state_e         state_q, state_d;
  logic              ready_q, ready_d;
  logic [4*NDIG-1:0] pending_q, pending_d;
  logic [4*NDIG-1:0] active_q, active_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [NDIG-1:0]   an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              frame_q, frame_d;
  logic              higher_nz;
  logic [3:0]        cur_nib;

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .clkin (clkin),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign frame_tick = tick && (idx_q == LAST_IDX);

  // Handshake FSM: state register
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ready_q   <= 1'b1;
      pending_q <= '0;
      active_q  <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      pending_q <= pending_d;
      active_q  <= active_d;
    end
  end

  // Handshake FSM: next state. A load taken on a frame tick lands in PEND
  // only after that tick, so its commit waits for the following frame.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    active_d  = active_q;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          pending_d = bcd_in;
          state_d   = ST_PEND;
        end
      end
      ST_PEND: begin
        if (frame_tick) begin
          active_d = pending_q;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake FSM: outputs, registered so ready tracks the current state
  always_comb begin
    ready_d = (state_d == ST_IDLE);
  end

  // Scan datapath
  always_comb begin
    higher_nz = 1'b0;
    for (int j = 0; j < int'(NDIG); j++) begin
      if (j >= int'(idx_q) && active_q[4*j +: 4] != 4'd0) higher_nz = 1'b1;
    end
    cur_nib = active_q[{idx_q, 2'b00} +: 4];

    idx_d   = idx_q;
    an_d    = an_q;
    seg_d   = seg_q;
    frame_d = 1'b0;
    if (tick) begin
      an_d        = '1;
      an_d[idx_q] = 1'b0;
      // Digit 0 is exempt so a zero value still shows a single "0"
      if (blank_lz && idx_q != '0 && !higher_nz) seg_d = SEG_BLANK;
      else                                       seg_d = seg_decode(cur_nib);
      frame_d = (idx_q == LAST_IDX);
      idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      an_q    <= '1;
      seg_q   <= SEG_BLANK;
      frame_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      frame_q <= frame_d;
    end
  end

  assign ready = ready_q;
  assign an    = an_q;
  assign seg   = seg_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// tb/tb_bcd_scan_ctrl.sv - directed self-checking bench for bcd_scan_ctrl
module tb_bcd_scan_ctrl;

  logic        clkin;
  logic        rst_n;
  logic        load;
  logic [15:0] bcd_in;
  logic        blank_lz;
  logic        ready;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        frame;

  int total = 0;
  int bad   = 0;

  bcd_scan_ctrl #(.DIV(4), .NDIG(4)) dut (
    .clkin    (clkin),
    .rst_n    (rst_n),
    .load     (load),
    .bcd_in   (bcd_in),
    .blank_lz (blank_lz),
    .ready    (ready),
    .an       (an),
    .seg      (seg),
    .frame    (frame)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  // Returns at the sample point just after the edge on which frame rose.
  task automatic wait_frame(input string nm);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(posedge clkin);
      #1;
      if (frame === 1'b1) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s: frame not seen within 100 cycles", nm);
    end
  endtask

  // Starting just after a frame edge, checks the next full scan.
  task automatic capture_scan(input logic [6:0] e0, input logic [6:0] e1,
                              input logic [6:0] e2, input logic [6:0] e3,
                              input string nm);
    logic [6:0] exp_seg [4];
    logic [3:0] exp_an;
    exp_seg[0] = e0; exp_seg[1] = e1; exp_seg[2] = e2; exp_seg[3] = e3;
    for (int k = 0; k < 4; k++) begin
      repeat (5) @(posedge clkin);
      #1;
      exp_an = 4'hF;
      exp_an[k] = 1'b0;
      total++;
      if (an !== exp_an) begin
        bad++;
        $display("FAIL %s an[d%0d]: got %h want %h", nm, k, an, exp_an);
      end
      total++;
      if (seg !== exp_seg[k]) begin
        bad++;
        $display("FAIL %s seg[d%0d]: got %h want %h", nm, k, seg, exp_seg[k]);
      end
      total++;
      if (frame !== (k == 3)) begin
        bad++;
        $display("FAIL %s frame[d%0d]: got %b want %b", nm, k, frame, (k == 3));
      end
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    @(negedge clkin);
    load   = 1'b1;
    bcd_in = v;
    @(posedge clkin);
    #1;
    load   = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    total++; if (an !== 4'hF)     begin bad++; $display("FAIL reset_an: got %h want f", an); end
    total++; if (seg !== 7'h7F)   begin bad++; $display("FAIL reset_seg: got %h want 7f", seg); end
    total++; if (frame !== 1'b0)  begin bad++; $display("FAIL reset_frame: got %b want 0", frame); end
    total++; if (ready !== 1'b1)  begin bad++; $display("FAIL reset_ready: got %b want 1", ready); end
  endtask

  // First tick lands on the 5th edge after release, then every 5 edges.
  task automatic test_scan;
    @(negedge clkin);
    rst_n = 1'b1;
    repeat (4) @(posedge clkin);
    #1;
    total++; if (an !== 4'hF) begin bad++; $display("FAIL scan_pre_tick_an: got %h want f", an); end
    @(posedge clkin);
    #1;
    total++; if (an !== 4'hE)    begin bad++; $display("FAIL scan_first_an: got %h want e", an); end
    total++; if (seg !== 7'h40)  begin bad++; $display("FAIL scan_first_seg: got %h want 40", seg); end
    total++; if (frame !== 1'b0) begin bad++; $display("FAIL scan_first_frame: got %b want 0", frame); end
    @(posedge clkin);
    #1;
    total++; if (an !== 4'hE)    begin bad++; $display("FAIL scan_hold_an: got %h want e", an); end
    repeat (4) @(posedge clkin);
    #1;
    total++; if (an !== 4'hD)    begin bad++; $display("FAIL scan_second_an: got %h want d", an); end
    wait_frame("scan_wait");
    total++; if (an !== 4'h7)    begin bad++; $display("FAIL scan_frame_an: got %h want 7", an); end
    @(posedge clkin);
    #1;
    total++; if (frame !== 1'b0) begin bad++; $display("FAIL scan_frame_width: got %b want 0", frame); end
    wait_frame("scan_wait2");
    capture_scan(7'h40, 7'h40, 7'h40, 7'h40, "scan_zero");
  endtask

  task automatic test_load;
    do_load(16'h1234);
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL load_ready_low: got %b want 0", ready); end
    do_load(16'h5678);
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL load_pend_ready: got %b want 0", ready); end
    wait_frame("load_commit");
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL load_ready_back: got %b want 1", ready); end
    capture_scan(7'h19, 7'h30, 7'h24, 7'h79, "load_1234");
    capture_scan(7'h19, 7'h30, 7'h24, 7'h79, "load_not_5678");
  endtask

  task automatic test_blank;
    blank_lz = 1'b1;
    do_load(16'h0040);
    wait_frame("blank_commit_0040");
    capture_scan(7'h40, 7'h19, 7'h7F, 7'h7F, "blank_0040");
    do_load(16'h0000);
    wait_frame("blank_commit_0000");
    capture_scan(7'h40, 7'h7F, 7'h7F, 7'h7F, "blank_0000");
    do_load(16'h0506);
    wait_frame("blank_commit_0506");
    capture_scan(7'h02, 7'h40, 7'h12, 7'h7F, "blank_0506");
  endtask

  task automatic test_nibble;
    blank_lz = 1'b0;
    do_load(16'h9A87);
    wait_frame("nibble_commit");
    capture_scan(7'h78, 7'h00, 7'h7F, 7'h10, "nibble_9a87");
  endtask

  // Load accepted on the very edge of a frame tick must wait one more scan.
  task automatic test_load_on_frame;
    wait_frame("lof_sync");
    repeat (19) @(posedge clkin);
    @(negedge clkin);
    load   = 1'b1;
    bcd_in = 16'h0123;
    @(posedge clkin);
    #1;
    load   = 1'b0;
    total++; if (frame !== 1'b1) begin bad++; $display("FAIL lof_frame: got %b want 1", frame); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL lof_ready: got %b want 0", ready); end
    capture_scan(7'h78, 7'h00, 7'h7F, 7'h10, "lof_old_value");
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL lof_commit_ready: got %b want 1", ready); end
    capture_scan(7'h30, 7'h24, 7'h79, 7'h40, "lof_new_value");
  endtask

  task automatic test_reset_pend;
    do_load(16'h8888);
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL rp_pend: got %b want 0", ready); end
    @(posedge clkin);
    #3;
    rst_n = 1'b0;
    #1;
    total++; if (an !== 4'hF)    begin bad++; $display("FAIL rp_an: got %h want f", an); end
    total++; if (seg !== 7'h7F)  begin bad++; $display("FAIL rp_seg: got %h want 7f", seg); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL rp_ready: got %b want 1", ready); end
    total++; if (frame !== 1'b0) begin bad++; $display("FAIL rp_frame: got %b want 0", frame); end
    @(negedge clkin);
    rst_n = 1'b1;
    repeat (5) @(posedge clkin);
    #1;
    total++; if (an !== 4'hE)   begin bad++; $display("FAIL rp_first_an: got %h want e", an); end
    total++; if (seg !== 7'h40) begin bad++; $display("FAIL rp_first_seg: got %h want 40", seg); end
    wait_frame("rp_frame_wait");
    capture_scan(7'h40, 7'h40, 7'h40, 7'h40, "rp_discarded");
  endtask

  initial begin
    rst_n    = 1'b0;
    load     = 1'b0;
    bcd_in   = 16'h0000;
    blank_lz = 1'b0;
    test_reset();
    test_scan();
    test_load();
    test_blank();
    test_nibble();
    test_load_on_frame();
    test_reset_pend();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
